// File: rtl/aes_pipe_ctl.sv
// ---------------------------------------------------------------------------
// aes_pipe_ctl
//
// Sequencer and flow controller sitting in front of a free-running,
// 10-round pipelined AES-128 encryption core. The core has no handshake of
// its own, so this block:
//   - accepts plaintext and key updates over valid/ready handshakes,
//   - issues accepted blocks into the core through a registered data port,
//   - tracks blocks inside the core with a valid shift register,
//   - captures ciphertext into a first-word-fall-through output FIFO,
//   - admits new blocks only while (in flight + queued) < FIFO_DEPTH, so the
//     core can never push a result into a full FIFO,
//   - swaps the cipher key only when nothing is inside the core.
//
// Optional feature macro: AES_CTL_STATS_EN
//   defined   -> blk_count counts FIFO writes (wraps at 2^32, cleared by rst)
//   undefined -> blk_count is tied to zero, no counter is built
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   s_valid/s_ready/s_data        plaintext input handshake (128-bit)
//   key_valid/key_ready/key_data  key update request; key_ready pulses for
//                                 one cycle when key_data is latched
//   m_valid/m_ready/m_data        ciphertext output (FIFO head)
//   cph_datain, cph_key           registered data and key to the core
//   cph_dataout                   ciphertext returning from the core
//   busy            high while blocks are in flight or no key is active
//   blk_count       completed-block counter (see macro above)
// ---------------------------------------------------------------------------
module aes_pipe_ctl #(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic [127:0] cph_datain,
  output logic [127:0] cph_key,
  input  logic [127:0] cph_dataout,
  output logic         busy,
  output logic [31:0]  blk_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {NOKEY, RUN, DRAIN, LOAD} state_t;

  state_t             state;
  logic [127:0]       key_q;
  logic               issue_v;
  logic [LATENCY-1:0] vld_sr;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [127:0]       mem [FIFO_DEPTH];
  logic [CNT_W:0]     credit_used;
  logic               accept;
  logic               fifo_wr;
  logic               fifo_rd;

  // Credits: every block inside the core already owns a FIFO slot, so the
  // sum of in-flight and queued blocks must stay below the FIFO depth.
  // The sum is one bit wider than the counters so it cannot wrap.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};

  // A pending key request blocks admission in the same cycle, so the
  // RUN -> DRAIN transition never races with an accept.
  assign s_ready = (state == RUN) && !key_valid &&
                   (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  assign accept  = s_valid && s_ready;
  assign fifo_wr = vld_sr[LATENCY-1];
  assign m_valid = (fifo_count != '0);
  assign fifo_rd = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];
  assign cph_key = key_q;
  assign busy    = (inflight != '0) || (state != RUN);

  // Key-management FSM. key_ready is registered and is high exactly while
  // the FSM sits in LOAD; key_q is captured on the edge that leaves LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NOKEY;
      key_q     <= '0;
      key_ready <= 1'b0;
    end else begin
      key_ready <= 1'b0;
      case (state)
        NOKEY: begin
          if (key_valid) begin
            state     <= LOAD;
            key_ready <= 1'b1;
          end
        end
        RUN: begin
          if (key_valid) state <= DRAIN;
        end
        DRAIN: begin
          // Wait until the core holds no tracked block before swapping keys.
          if (inflight == '0) begin
            state     <= LOAD;
            key_ready <= 1'b1;
          end
        end
        LOAD: begin
          key_q <= key_data;
          state <= RUN;
        end
        default: state <= NOKEY;
      endcase
    end
  end

  // Issue register: the core sees a stable cph_datain; issue_v marks the
  // cycle in which it carries a genuine block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cph_datain <= '0;
      issue_v    <= 1'b0;
    end else begin
      issue_v <= accept;
      if (accept) cph_datain <= s_data;
    end
  end

  // Valid shift register mirroring the core pipeline; its last stage lines
  // up with the matching ciphertext on cph_dataout. Clearing it on reset is
  // what discards whatever the core still holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= issue_v;
      for (int i = 1; i < LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  // In-flight counter: a block leaves flight when it lands in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (accept && !fifo_wr) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!accept && fifo_wr) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  // FIFO occupancy and pointers; pointers wrap naturally since the depth
  // is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_wr && !fifo_rd) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!fifo_wr && fifo_rd) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // FIFO storage carries no reset; only the pointers and count define
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= cph_dataout;
  end

`ifdef AES_CTL_STATS_EN
  logic [31:0] blk_count_q;

  // Completed-block statistic, one count per ciphertext written.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count_q <= '0;
    end else if (fifo_wr) begin
      blk_count_q <= blk_count_q + 32'd1;
    end
  end

  assign blk_count = blk_count_q;
`else
  assign blk_count = '0;
`endif

endmodule
